// File: rtl/axo_wb_ctrl_pkg.sv
// axo_defines: shared constants for the write-back controller and its requesters
package axo_defines;
   localparam int RF_IDX_W = 5;
   localparam int NREQ_MAX = 8;
   localparam int WB_ALU   = 0;
   localparam int WB_MEM   = 1;
   localparam int WB_CSR   = 2;
endpackage

// File: rtl/axo_wb_ctrl_rr_arbiter.sv
// axo_rr_arbiter: combinational round-robin arbiter with a registered priority pointer
module axo_rr_arbiter #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant
);
   localparam int PW = N > 1 ? $clog2(N) : 1;
   logic [PW-1:0] ptr;
   logic [PW-1:0] gidx;
   logic          any;
   int            idx;
   // grant the first requester at or after the pointer, wrapping modulo N
   always_comb begin
      grant = '0;
      gidx  = '0;
      any   = 1'b0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            gidx       = PW'(idx);
         end
      end
   end
   // pointer moves just past the winner; holds when nothing was granted
   always_ff @(posedge clk) begin
      if (rst) ptr <= '0;
      else if (any) ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
   end
endmodule

// File: rtl/axo_wb_ctrl.sv
// axo_wb_ctrl: regfile write-port arbitration with a RAW/WAW pending scoreboard
module axo_wb_ctrl
   import axo_defines::*;
#(
   parameter int XLEN = 32,
   parameter int NREQ = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     iss_valid,
   input  logic [RF_IDX_W-1:0]      iss_rs1,
   input  logic [RF_IDX_W-1:0]      iss_rs2,
   input  logic [RF_IDX_W-1:0]      iss_rd,
   input  logic                     iss_has_rs1,
   input  logic                     iss_has_rs2,
   input  logic                     iss_has_rd,
   output logic                     iss_stall,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*RF_IDX_W-1:0] req_rd,
   input  logic [NREQ*XLEN-1:0]     req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic                     rf_we,
   output logic [RF_IDX_W-1:0]      rf_rd,
   output logic [XLEN-1:0]          rf_din,
   output logic [30:0]              pending,
   output logic                     err_unexpected
);
   logic [31:0] pend;
   logic        accept;
   axo_rr_arbiter #(.N(NREQ)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (req_valid),
      .grant (req_ready)
   );
   assign pending = pend[31:1];
   // hazard check against in-flight writes; x0 never blocks
   always_comb begin
      iss_stall = iss_valid && ((iss_has_rs1 && iss_rs1 != '0 && pend[iss_rs1]) ||
                                (iss_has_rs2 && iss_rs2 != '0 && pend[iss_rs2]) ||
                                (iss_has_rd  && iss_rd  != '0 && pend[iss_rd]));
      accept    = iss_valid && !iss_stall;
   end
   // steer the granted requester onto the write port; zeros when idle
   always_comb begin
      rf_rd  = '0;
      rf_din = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i]) begin
            rf_rd  = req_rd[i*RF_IDX_W +: RF_IDX_W];
            rf_din = req_data[i*XLEN +: XLEN];
         end
      end
      rf_we = |req_ready && rf_rd != '0;
   end
   // scoreboard: clear on write-back, set on accepted issue (set assigned last so it wins)
   always_ff @(posedge clk) begin
      if (rst) begin
         pend           <= '0;
         err_unexpected <= 1'b0;
      end else begin
         if (rf_we) pend[rf_rd] <= 1'b0;
         if (accept && iss_has_rd && iss_rd != '0) pend[iss_rd] <= 1'b1;
         if (rf_we && !pend[rf_rd]) err_unexpected <= 1'b1;
      end
   end
endmodule

// File: tb/tb_axo_wb_ctrl.sv
// tb_axo_wb_ctrl: directed-vector self-checking bench for axo_wb_ctrl
module tb_axo_wb_ctrl;
   import axo_defines::*;
   localparam int XLEN = 32;
   localparam int NREQ = 3;
   logic              clk = 1'b0;
   logic              rst;
   logic              iss_valid, iss_has_rs1, iss_has_rs2, iss_has_rd, iss_stall;
   logic [4:0]        iss_rs1, iss_rs2, iss_rd;
   logic [NREQ-1:0]   req_valid, req_ready;
   logic [NREQ*5-1:0] req_rd;
   logic [NREQ*XLEN-1:0] req_data;
   logic              rf_we, err_unexpected;
   logic [4:0]        rf_rd;
   logic [XLEN-1:0]   rf_din;
   logic [30:0]       pending;
   int                n_cmp = 0;
   int                n_bad = 0;

   axo_wb_ctrl #(.XLEN(XLEN), .NREQ(NREQ)) dut (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
      .iss_has_rs1(iss_has_rs1), .iss_has_rs2(iss_has_rs2), .iss_has_rd(iss_has_rd),
      .iss_stall(iss_stall),
      .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_din(rf_din),
      .pending(pending), .err_unexpected(err_unexpected)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] rd, input logic has_rd, input logic [4:0] rs1, input logic has_rs1);
      iss_valid   = 1'b1;
      iss_rd      = rd;
      iss_has_rd  = has_rd;
      iss_rs1     = rs1;
      iss_has_rs1 = has_rs1;
      iss_rs2     = '0;
      iss_has_rs2 = 1'b0;
   endtask

   task automatic no_issue;
      iss_valid = 1'b0; iss_has_rd = 1'b0; iss_has_rs1 = 1'b0; iss_has_rs2 = 1'b0;
      iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
   endtask

   task automatic wb(input int i, input logic [4:0] rd, input logic [XLEN-1:0] d);
      req_valid[i]          = 1'b1;
      req_rd[i*5 +: 5]      = rd;
      req_data[i*XLEN +: XLEN] = d;
   endtask

   task automatic no_wb;
      req_valid = '0; req_rd = '0; req_data = '0;
   endtask

   initial begin
      rst = 1'b1;
      no_issue();
      no_wb();
      tick(); tick();
      rst = 1'b0;
      #1;
      check("rst_pending", 64'(pending), 64'h0);
      check("rst_stall", 64'(iss_stall), 64'h0);
      check("rst_err", 64'(err_unexpected), 64'h0);
      check("rst_ready", 64'(req_ready), 64'h0);
      check("rst_we", 64'(rf_we), 64'h0);

      // 1: mark x5, RAW stall, write back from MEM, stall drops
      issue(5'd5, 1'b1, 5'd0, 1'b0);
      #1 check("t1_issue_nostall", 64'(iss_stall), 64'h0);
      tick();
      no_issue();
      #1 check("t1_pend5", 64'(pending), 64'h10);
      issue(5'd0, 1'b0, 5'd5, 1'b1);
      #1 check("t1_raw_stall", 64'(iss_stall), 64'h1);
      wb(WB_MEM, 5'd5, 32'hDEADBEEF);
      #1;
      check("t1_ready", 64'(req_ready), 64'h2);
      check("t1_we", 64'(rf_we), 64'h1);
      check("t1_rd", 64'(rf_rd), 64'h5);
      check("t1_din", 64'(rf_din), 64'hDEADBEEF);
      check("t1_still_stall", 64'(iss_stall), 64'h1);
      tick();
      no_wb();
      #1;
      check("t1_pend_clr", 64'(pending), 64'h0);
      check("t1_stall_drop", 64'(iss_stall), 64'h0);
      tick();
      no_issue();

      // 2: pointer sits at 2 after the MEM grant; rotation 2,0,1 then 2 again
      issue(5'd1, 1'b1, 5'd0, 1'b0); tick();
      issue(5'd2, 1'b1, 5'd0, 1'b0); tick();
      issue(5'd3, 1'b1, 5'd0, 1'b0); tick();
      no_issue();
      #1 check("t2_pend123", 64'(pending), 64'h7);
      wb(WB_ALU, 5'd1, 32'h11); wb(WB_MEM, 5'd2, 32'h22); wb(WB_CSR, 5'd3, 32'h33);
      #1;
      check("t2_g0_ready", 64'(req_ready), 64'h4);
      check("t2_g0_din", 64'(rf_din), 64'h33);
      tick();
      #1;
      check("t2_g1_ready", 64'(req_ready), 64'h1);
      check("t2_g1_rd", 64'(rf_rd), 64'h1);
      tick();
      #1;
      check("t2_g2_ready", 64'(req_ready), 64'h2);
      check("t2_g2_rd", 64'(rf_rd), 64'h2);
      tick();
      wb(WB_ALU, 5'd0, 32'h0); wb(WB_MEM, 5'd0, 32'h0); wb(WB_CSR, 5'd0, 32'h0);
      #1;
      check("t2_g3_ready", 64'(req_ready), 64'h4);
      check("t2_g3_we", 64'(rf_we), 64'h0);
      tick();
      no_wb();
      #1;
      check("t2_pend_clr", 64'(pending), 64'h0);
      check("t2_err", 64'(err_unexpected), 64'h0);

      // 3: x0 never pending; write-back to x0 is consumed silently (pointer 0 -> MEM wins alone)
      issue(5'd0, 1'b1, 5'd0, 1'b1);
      #1 check("t3_x0_nostall", 64'(iss_stall), 64'h0);
      tick();
      no_issue();
      #1 check("t3_x0_pend", 64'(pending), 64'h0);
      wb(WB_MEM, 5'd0, 32'hABCD);
      #1;
      check("t3_ready", 64'(req_ready), 64'h2);
      check("t3_we", 64'(rf_we), 64'h0);
      tick();
      no_wb();
      #1 check("t3_err", 64'(err_unexpected), 64'h0);

      // 4: WAW on x7 (pointer 2, ALU requests alone)
      issue(5'd7, 1'b1, 5'd0, 1'b0); tick();
      #1 check("t4_pend7", 64'(pending), 64'h40);
      check("t4_waw_stall", 64'(iss_stall), 64'h1);
      tick();
      #1 check("t4_waw_hold", 64'(iss_stall), 64'h1);
      wb(WB_ALU, 5'd7, 32'h77);
      #1 check("t4_ready", 64'(req_ready), 64'h1);
      tick();
      no_wb();
      #1 check("t4_stall_drop", 64'(iss_stall), 64'h0);
      tick();
      no_issue();
      #1 check("t4_pend7_again", 64'(pending), 64'h40);
      wb(WB_CSR, 5'd7, 32'h78);
      #1 check("t4_cleanup_ready", 64'(req_ready), 64'h4);
      tick();
      no_wb();
      #1 check("t4_pend_clr", 64'(pending), 64'h0);

      // 5: unexpected write-back to x9 (pointer 0, MEM alone)
      wb(WB_MEM, 5'd9, 32'h99);
      #1;
      check("t5_we", 64'(rf_we), 64'h1);
      check("t5_rd", 64'(rf_rd), 64'h9);
      check("t5_err_before", 64'(err_unexpected), 64'h0);
      tick();
      no_wb();
      #1;
      check("t5_err", 64'(err_unexpected), 64'h1);
      check("t5_pend", 64'(pending), 64'h0);
      tick(); tick();
      #1 check("t5_err_sticky", 64'(err_unexpected), 64'h1);

      // 6: reset mid-operation with x3/x4 pending and all requesters valid (pointer 2)
      issue(5'd3, 1'b1, 5'd0, 1'b0); tick();
      issue(5'd4, 1'b1, 5'd0, 1'b0); tick();
      no_issue();
      #1 check("t6_pend34", 64'(pending), 64'h0C);
      wb(WB_ALU, 5'd0, 32'h1); wb(WB_MEM, 5'd0, 32'h2); wb(WB_CSR, 5'd0, 32'h3);
      rst = 1'b1;
      #1 check("t6_rst_grant", 64'(req_ready), 64'h4);
      tick();
      rst = 1'b0;
      #1;
      check("t6_pend", 64'(pending), 64'h0);
      check("t6_err", 64'(err_unexpected), 64'h0);
      check("t6_first_grant", 64'(req_ready), 64'h1);
      check("t6_din", 64'(rf_din), 64'h1);
      tick();
      no_wb();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/axo_wb_ctrl.md
Name: axo_wb_ctrl

Overview:
- Write-back controller for the XLEN-bit dual-read, single-write register file.
- Shares the single write port between NREQ result producers (ALU, load unit, CSR/mul-div) using round-robin arbitration.
- Keeps a per-register pending scoreboard and stalls issue on RAW and WAW hazards against in-flight writes.
- Sits between the decode/issue stage, which supplies register-presence flags from the register decoder, and the regfile write port.

Parameters:
- XLEN, 32, register/data width.
- NREQ, 3, number of write-back requesters; legal range 2..8.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset, sampled on rising edge of clk.
- iss_valid  in  1  decode stage presents an instruction.
- iss_rs1  in  5  source register 1 index.
- iss_rs2  in  5  source register 2 index.
- iss_rd  in  5  destination register index.
- iss_has_rs1  in  1  instruction reads rs1.
- iss_has_rs2  in  1  instruction reads rs2.
- iss_has_rd  in  1  instruction writes rd.
- iss_stall  out  1  issue must hold this cycle.
- req_valid  in  NREQ  per-requester write-back valid.
- req_rd  in  NREQ*5  per-requester destination index, packed; requester i at [5i+4:5i].
- req_data  in  NREQ*XLEN  per-requester result, packed likewise.
- req_ready  out  NREQ  grant, one-hot or zero.
- rf_we  out  1  regfile write enable.
- rf_rd  out  5  regfile write index.
- rf_din  out  XLEN  regfile write data.
- pending  out  31  scoreboard bits for x1..x31; bit k-1 corresponds to xk.
- err_unexpected  out  1  sticky; set when a write-back targets a non-pending register.

Behaviour:
- Reset: pending = 0, round-robin pointer = 0, err_unexpected = 0.
- During reset and in the cycle after it, all combinational outputs follow from the reset state: iss_stall = 0, and req_ready/rf_we are driven by arbitration.
- Hazard detection is combinational from registered pending; there is no bypass.
  - iss_stall = iss_valid && ((iss_has_rs1 && rs1!=0 && pending[rs1]) || (iss_has_rs2 && rs2!=0 && pending[rs2]) || (iss_has_rd && rd!=0 && pending[rd])).
- Issue acceptance: iss_valid && !iss_stall.
  - If additionally iss_has_rd && rd!=0, pending[rd] is set at the next edge.
  - x0 is never marked pending.
- Arbitration: combinational round-robin.
  - Search starts at the pointer index and wraps modulo NREQ; the first requester with req_valid is granted.
  - req_ready[g] = 1 for the granted index g only.
  - At most one grant per cycle; latency from req_valid to grant is 0 cycles when no contention.
  - On a grant, the pointer becomes (g+1) mod NREQ at the next edge. With no grant, the pointer holds.
  - Requester rule: req_valid, once raised, holds with stable req_rd/req_data until req_ready. The controller does not check this.
- Regfile drive:
  - rf_rd = req_rd[g] and rf_din = req_data[g].
  - rf_we = grant && req_rd[g]!=0. When rd is x0, the request is still granted (consumed) but no write occurs.
  - With no grant: rf_we = 0, rf_rd = 0, rf_din = 0.
- Scoreboard clear: on a grant with rd!=0, pending[rd] is cleared at the next edge.
  - Data is visible on the regfile read ports the cycle after the grant, which is the same cycle iss_stall drops.
- Simultaneous set and clear of the same index:
  - This is unreachable through legal issue, because the WAW stall blocks it.
  - If it does occur, set wins.
- err_unexpected is set at the next edge when a grant has rd!=0 && !pending[rd].
  - The write still happens and pending stays 0.
  - It is cleared only by rst.
- Reset asserted mid-operation:
  - Any in-flight results are abandoned and the scoreboard is cleared.
  - While rst is high, grants are still computed combinationally, but no state updates other than the reset values.

Decomposition:
- Shared package (axo_defines):
  - constant for the regfile index width (5);
  - constant for the NREQ maximum;
  - requester-index localparams (WB_ALU=0, WB_MEM=1, WB_CSR=2).
- One sub-module: axo_rr_arbiter.
  - Parameter N; inputs clk, rst, req[N]; output grant[N] one-hot.
  - Owns the pointer and is reusable for future bus arbitration.
- Scoreboard and muxing stay in axo_wb_ctrl.

Test Plan:
1. Reset, then issue rd=5 (rs1/rs2 absent) -> pending[x5]=1 next cycle. Issue reading rs1=5 -> iss_stall=1. Requester 1 writes rd=5, data=0xDEADBEEF -> rf_we=1, rf_rd=5, rf_din=0xDEADBEEF; next cycle pending[x5]=0 and iss_stall=0.
2. All three req_valid high continuously, rds 1, 2, 3 pending -> grants 0,1,2,0... in successive cycles, exactly one req_ready per cycle.
3. Issue with rd=0 and has_rd=1 -> pending unchanged, iss_stall never asserted for x0. Write-back with rd=0 -> req_ready=1, rf_we=0, err_unexpected stays 0.
4. pending[x7]=1, issue with rd=7 and no sources -> iss_stall=1 (WAW). After the write-back of x7 -> iss_stall=0 and pending[x7]=1 again after acceptance.
5. Write-back rd=9 while x9 is not pending -> rf_we=1 and err_unexpected=1 next cycle, remaining set until rst.
6. pending x3, x4 and req_valid held, assert rst for 1 cycle -> pending=0, pointer=0, err_unexpected=0 after the edge. The first post-reset grant goes to requester 0 when all are valid.
